// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline register.
package pipe_pkg;

  localparam int MAX_STAGES = 8;

  // Occupancy counter width: must represent 0..2*stages inclusive.
  function automatic int occ_width(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/skid_stage.sv
// One elastic stage: a main register feeding downstream plus a one-entry skid
// register that absorbs the single in-flight entry accepted while the main
// register is stalled. Upstream ready comes straight from a flop.
module skid_stage #(
  parameter int WIDTH = 154
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic             r_main_v;
  logic             r_skid_v;
  logic [WIDTH-1:0] r_main_d;
  logic [WIDTH-1:0] r_skid_d;

  logic             w_in_xfer;
  logic             w_main_free;

  assign w_in_xfer   = in_valid & ~r_skid_v;
  assign w_main_free = ~r_main_v | out_ready;

  assign in_ready  = ~r_skid_v;
  assign out_valid = r_main_v;
  assign out_data  = r_main_d;

  // Valid bits: refill main from skid first (FIFO order), else from input;
  // park the input in skid when main is stuck. Flush kills both entries.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (flush) begin
      r_main_v <= 1'b0;
      r_skid_v <= 1'b0;
    end else if (w_main_free) begin
      if (r_skid_v) begin
        r_main_v <= 1'b1;
        r_skid_v <= 1'b0;
      end else begin
        r_main_v <= in_valid;
      end
    end else if (w_in_xfer) begin
      r_skid_v <= 1'b1;
    end
  end

  // Payload registers follow the same moves as the valids; flush leaves them alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_main_d <= '0;
      r_skid_d <= '0;
    end else if (w_main_free) begin
      if (r_skid_v) begin
        r_main_d <= r_skid_d;
      end else if (in_valid) begin
        r_main_d <= in_data;
      end
    end else if (w_in_xfer) begin
      r_skid_d <= in_data;
    end
  end

endmodule

// File: rtl/elastic_pipe_reg.sv
// Chain of STAGES skid stages with a valid/ready handshake, global flush and
// an occupancy count of every live entry in the chain.
module elastic_pipe_reg
  import pipe_pkg::*;
#(
  parameter  int WIDTH  = 154,
  parameter  int STAGES = 1,
  localparam int OCC_W  = occ_width(STAGES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  input  logic             flush,
  output logic [OCC_W-1:0] occupancy
);

  if (STAGES < 1 || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("elastic_pipe_reg: STAGES=%0d outside 1..%0d", STAGES, MAX_STAGES);
  end

  logic             w_valid [STAGES+1];
  logic             w_ready [STAGES+1];
  logic [WIDTH-1:0] w_data  [STAGES+1];
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic [OCC_W-1:0] r_occ;

  assign w_valid[0]      = in_valid;
  assign w_data[0]       = in_data;
  assign in_ready        = w_ready[0];
  assign out_valid       = w_valid[STAGES];
  assign out_data        = w_data[STAGES];
  assign w_ready[STAGES] = out_ready;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    skid_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .in_valid (w_valid[g]),
      .in_data  (w_data[g]),
      .in_ready (w_ready[g]),
      .out_valid(w_valid[g+1]),
      .out_data (w_data[g+1]),
      .out_ready(w_ready[g+1])
    );
  end

  // Internal hops conserve entries, so only the two end interfaces move the count.
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = out_valid & out_ready;

  // Occupancy tracks entries accepted minus entries delivered; flush zeroes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_occ <= '0;
    end else if (flush) begin
      r_occ <= '0;
    end else begin
      r_occ <= r_occ + OCC_W'(w_in_xfer) - OCC_W'(w_out_xfer);
    end
  end

  assign occupancy = r_occ;

endmodule

// File: tb/tb_elastic_pipe_reg.sv
`timescale 1ns/1ps
module tb_elastic_pipe_reg;

  localparam int W  = 154;
  localparam int ND = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid  [ND];
  logic         in_ready  [ND];
  logic         out_valid [ND];
  logic         out_ready [ND];
  logic         flush     [ND];
  logic [W-1:0] in_data   [ND];
  logic [W-1:0] out_data  [ND];
  logic [1:0]   occ_s1;
  logic [2:0]   occ_s2;
  logic [2:0]   occ_s3;
  logic [4:0]   occ_s8;
  logic [4:0]   occ       [ND];

  assign occ[0] = {3'b0, occ_s1};
  assign occ[1] = {2'b0, occ_s2};
  assign occ[2] = {2'b0, occ_s3};
  assign occ[3] = occ_s8;

  int vecs = 0;
  int errs = 0;

  elastic_pipe_reg #(.WIDTH(W), .STAGES(1)) u_s1 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_data(in_data[0]), .in_ready(in_ready[0]),
    .out_valid(out_valid[0]), .out_data(out_data[0]), .out_ready(out_ready[0]), .flush(flush[0]),
    .occupancy(occ_s1));
  elastic_pipe_reg #(.WIDTH(W), .STAGES(2)) u_s2 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_data(in_data[1]), .in_ready(in_ready[1]),
    .out_valid(out_valid[1]), .out_data(out_data[1]), .out_ready(out_ready[1]), .flush(flush[1]),
    .occupancy(occ_s2));
  elastic_pipe_reg #(.WIDTH(W), .STAGES(3)) u_s3 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_data(in_data[2]), .in_ready(in_ready[2]),
    .out_valid(out_valid[2]), .out_data(out_data[2]), .out_ready(out_ready[2]), .flush(flush[2]),
    .occupancy(occ_s3));
  elastic_pipe_reg #(.WIDTH(W), .STAGES(8)) u_s8 (
    .clk(clk), .reset(reset), .in_valid(in_valid[3]), .in_data(in_data[3]), .in_ready(in_ready[3]),
    .out_valid(out_valid[3]), .out_data(out_data[3]), .out_ready(out_ready[3]), .flush(flush[3]),
    .occupancy(occ_s8));

  function automatic int stages_of(input int k);
    case (k)
      0:       return 1;
      1:       return 2;
      2:       return 3;
      default: return 8;
    endcase
  endfunction

  // Spread a 32-bit tag over the full payload so every bit position is exercised.
  function automatic logic [W-1:0] mk(input logic [31:0] v);
    return {v, ~v, v, ~v, v[25:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    for (int k = 0; k < ND; k++) begin
      in_valid[k]  = 1'b0;
      in_data[k]   = '0;
      out_ready[k] = 1'b0;
      flush[k]     = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int k = 0; k < ND; k++) begin
      in_valid[k]  = 1'b1;
      in_data[k]   = mk(32'(k + 1));
      out_ready[k] = 1'b1;
      flush[k]     = 1'b0;
    end
    repeat (3) begin
      step();
      for (int k = 0; k < ND; k++) begin
        vecs++;
        if (out_valid[k] !== 1'b0) begin
          errs++; $display("FAIL reset_out_valid dut%0d got %b want 0", k, out_valid[k]);
        end
        vecs++;
        if (in_ready[k] !== 1'b1) begin
          errs++; $display("FAIL reset_in_ready dut%0d got %b want 1", k, in_ready[k]);
        end
        vecs++;
        if (occ[k] !== 5'd0) begin
          errs++; $display("FAIL reset_occ dut%0d got %0d want 0", k, occ[k]);
        end
        vecs++;
        if (out_data[k] !== '0) begin
          errs++; $display("FAIL reset_out_data dut%0d got %h want 0", k, out_data[k]);
        end
      end
    end
    idle_all();
    reset = 1'b1;
    step();
  endtask

  task automatic test_streaming();
    int exp_in, exp_out;
    logic exp_ov;
    idle_all();
    out_ready[2] = 1'b1;
    for (int c = 0; c < 14; c++) begin
      exp_in  = (c < 10) ? c : 10;
      exp_out = (c > 3) ? ((c - 3 < 10) ? c - 3 : 10) : 0;
      exp_ov  = (c >= 3) && (c <= 12);
      vecs++;
      if (in_ready[2] !== 1'b1) begin
        errs++; $display("FAIL stream_in_ready cyc%0d got %b want 1", c, in_ready[2]);
      end
      vecs++;
      if (out_valid[2] !== exp_ov) begin
        errs++; $display("FAIL stream_out_valid cyc%0d got %b want %b", c, out_valid[2], exp_ov);
      end
      if (exp_ov) begin
        vecs++;
        if (out_data[2] !== mk(32'(c - 2))) begin
          errs++; $display("FAIL stream_out_data cyc%0d got %h want %h", c, out_data[2], mk(32'(c - 2)));
        end
      end
      vecs++;
      if (occ[2] !== 5'(exp_in - exp_out)) begin
        errs++; $display("FAIL stream_occ cyc%0d got %0d want %0d", c, occ[2], exp_in - exp_out);
      end
      in_valid[2] = (c < 10);
      in_data[2]  = mk(32'(c + 1));
      step();
    end
    idle_all();
  endtask

  task automatic test_backpressure();
    int accepted, n;
    logic xfer;
    idle_all();
    accepted    = 0;
    in_valid[1] = 1'b1;
    in_data[1]  = mk(32'h10);
    repeat (8) begin
      xfer = in_valid[1] & in_ready[1];
      step();
      if (xfer) begin
        accepted++;
        in_data[1] = mk(32'(32'h10 + accepted));
      end
    end
    vecs++;
    if (accepted != 4) begin
      errs++; $display("FAIL bp_accepted got %0d want 4", accepted);
    end
    vecs++;
    if (in_ready[1] !== 1'b0) begin
      errs++; $display("FAIL bp_in_ready got %b want 0", in_ready[1]);
    end
    vecs++;
    if (occ[1] !== 5'd4) begin
      errs++; $display("FAIL bp_occ got %0d want 4", occ[1]);
    end
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b1;
    n = 0;
    repeat (8) begin
      if (out_valid[1] === 1'b1) begin
        vecs++;
        if (n >= 4 || out_data[1] !== mk(32'(32'h10 + n))) begin
          errs++; $display("FAIL bp_drain_data idx%0d got %h want %h", n, out_data[1], mk(32'(32'h10 + n)));
        end
        n++;
      end
      step();
    end
    vecs++;
    if (n != 4) begin
      errs++; $display("FAIL bp_drain_count got %0d want 4", n);
    end
    vecs++;
    if (occ[1] !== 5'd0) begin
      errs++; $display("FAIL bp_drain_occ got %0d want 0", occ[1]);
    end
    idle_all();
  endtask

  task automatic test_flush();
    idle_all();
    for (int i = 0; i < 3; i++) begin
      in_valid[1] = 1'b1;
      in_data[1]  = mk(32'(32'h20 + i));
      step();
    end
    vecs++;
    if (occ[1] !== 5'd3) begin
      errs++; $display("FAIL flush_pre_occ got %0d want 3", occ[1]);
    end
    flush[1]    = 1'b1;
    in_valid[1] = 1'b1;
    in_data[1]  = mk(32'hEE);
    step();
    flush[1]     = 1'b0;
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b1;
    vecs++;
    if (out_valid[1] !== 1'b0) begin
      errs++; $display("FAIL flush_out_valid got %b want 0", out_valid[1]);
    end
    vecs++;
    if (occ[1] !== 5'd0) begin
      errs++; $display("FAIL flush_occ got %0d want 0", occ[1]);
    end
    vecs++;
    if (in_ready[1] !== 1'b1) begin
      errs++; $display("FAIL flush_in_ready got %b want 1", in_ready[1]);
    end
    for (int c = 0; c < 6; c++) begin
      step();
      vecs++;
      if (out_valid[1] !== 1'b0) begin
        errs++; $display("FAIL flush_leak cyc%0d got valid %b data %h want no output", c, out_valid[1], out_data[1]);
      end
    end
    in_valid[1] = 1'b1;
    in_data[1]  = mk(32'h55);
    step();
    in_valid[1] = 1'b0;
    step();
    vecs++;
    if (out_valid[1] !== 1'b1 || out_data[1] !== mk(32'h55)) begin
      errs++; $display("FAIL flush_resume got valid %b data %h want 1 %h", out_valid[1], out_data[1], mk(32'h55));
    end
    step();
    vecs++;
    if (out_valid[1] !== 1'b0 || occ[1] !== 5'd0) begin
      errs++; $display("FAIL flush_resume_empty got valid %b occ %0d want 0 0", out_valid[1], occ[1]);
    end
    idle_all();
  endtask

  task automatic test_async_reset();
    idle_all();
    out_ready[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid[2] = 1'b1;
      in_data[2]  = mk(32'(32'h30 + i));
      step();
    end
    in_data[2] = mk(32'h34);
    vecs++;
    if (out_valid[2] !== 1'b1 || out_data[2] !== mk(32'h31)) begin
      errs++; $display("FAIL areset_pre got valid %b data %h want 1 %h", out_valid[2], out_data[2], mk(32'h31));
    end
    #3;
    reset = 1'b0;
    #1;
    vecs++;
    if (out_valid[2] !== 1'b0 || in_ready[2] !== 1'b1 || occ[2] !== 5'd0) begin
      errs++; $display("FAIL areset_immediate got valid %b ready %b occ %0d want 0 1 0", out_valid[2], in_ready[2], occ[2]);
    end
    @(posedge clk);
    #1;
    vecs++;
    if (out_valid[2] !== 1'b0 || occ[2] !== 5'd0 || out_data[2] !== '0) begin
      errs++; $display("FAIL areset_hold got valid %b occ %0d data %h want 0 0 0", out_valid[2], occ[2], out_data[2]);
    end
    #3;
    reset       = 1'b1;
    in_valid[2] = 1'b1;
    in_data[2]  = mk(32'h77);
    step();
    in_valid[2] = 1'b0;
    step();
    step();
    vecs++;
    if (out_valid[2] !== 1'b1 || out_data[2] !== mk(32'h77)) begin
      errs++; $display("FAIL areset_resume got valid %b data %h want 1 %h", out_valid[2], out_data[2], mk(32'h77));
    end
    step();
    vecs++;
    if (out_valid[2] !== 1'b0 || occ[2] !== 5'd0) begin
      errs++; $display("FAIL areset_resume_empty got valid %b occ %0d want 0 0", out_valid[2], occ[2]);
    end
    idle_all();
  endtask

  task automatic test_random();
    logic [31:0] sb [ND][32];
    int          hd   [ND];
    int          tl   [ND];
    logic [31:0] nxt  [ND];
    logic [31:0] cur  [ND];
    logic        pend [ND];
    logic        ir   [ND];
    int          cnt, cap;
    idle_all();
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    for (int k = 0; k < ND; k++) begin
      hd[k] = 0; tl[k] = 0; nxt[k] = 32'h1000 * (k + 1); cur[k] = '0; pend[k] = 1'b0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int k = 0; k < ND; k++) begin
        cnt = tl[k] - hd[k];
        cap = 2 * stages_of(k);
        vecs++;
        if (occ[k] !== 5'(cnt)) begin
          errs++; $display("FAIL rand_occ dut%0d cyc%0d got %0d want %0d", k, cyc, occ[k], cnt);
        end
        vecs++;
        if (int'(occ[k]) > cap) begin
          errs++; $display("FAIL rand_occ_bound dut%0d cyc%0d got %0d want <= %0d", k, cyc, occ[k], cap);
        end
        if (out_valid[k] === 1'b1) begin
          vecs++;
          if (cnt == 0) begin
            errs++; $display("FAIL rand_spurious dut%0d cyc%0d got data %h want no output", k, cyc, out_data[k]);
          end else if (out_data[k] !== mk(sb[k][hd[k] % 32])) begin
            errs++; $display("FAIL rand_order dut%0d cyc%0d got %h want %h", k, cyc, out_data[k], mk(sb[k][hd[k] % 32]));
          end
        end
        if (cnt == 0) begin
          vecs++;
          if (in_ready[k] !== 1'b1) begin
            errs++; $display("FAIL rand_ready_empty dut%0d cyc%0d got %b want 1", k, cyc, in_ready[k]);
          end
        end
        if (cnt == cap) begin
          vecs++;
          if (in_ready[k] !== 1'b0) begin
            errs++; $display("FAIL rand_ready_full dut%0d cyc%0d got %b want 0", k, cyc, in_ready[k]);
          end
        end
        if (!pend[k]) begin
          in_valid[k] = 1'($urandom_range(0, 1));
          cur[k]      = nxt[k];
          in_data[k]  = mk(cur[k]);
        end
        out_ready[k] = 1'($urandom_range(0, 1));
      end
      #1;
      for (int k = 0; k < ND; k++) begin
        ir[k]        = in_ready[k];
        out_ready[k] = ~out_ready[k];
      end
      #1;
      for (int k = 0; k < ND; k++) begin
        vecs++;
        if (in_ready[k] !== ir[k]) begin
          errs++; $display("FAIL rand_ready_comb dut%0d cyc%0d got %b want %b", k, cyc, in_ready[k], ir[k]);
        end
        out_ready[k] = ~out_ready[k];
      end
      #1;
      for (int k = 0; k < ND; k++) begin
        if (out_valid[k] && out_ready[k] && (tl[k] != hd[k])) hd[k]++;
        if (in_valid[k] && in_ready[k]) begin
          sb[k][tl[k] % 32] = cur[k];
          tl[k]++;
          nxt[k] = nxt[k] + 1;
        end
        pend[k] = in_valid[k] & ~in_ready[k];
      end
      step();
    end
    idle_all();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog time limit reached, vectors %0d", vecs);
    $fatal(1, "timeout");
  end

endmodule
